display_feed: RTL and testbench

Upstream feeder for the 8-digit seven-segment display driver. Selects one of four 32-bit CPU status words (e.g. cycle count, PC, branch count, syscall output), steps between them with a debounced push-button, and optionally freezes the shown value. It delivers a registered 32-bit `data` word that the display driver splits into eight 4-bit digits. An optional sequential binary-to-BCD converter makes the digits read as decimal.

---
 rtl/display_feed_if.sv | 23 ++
 rtl/display_feed.sv | 139 +++++++++++++
 tb/tb_display_feed.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/display_feed_if.sv
// Bundle between the CPU status feeder and its consumer: raw button, freeze level,
// four candidate status words and the selected index, display word and busy flag.
interface display_feed_if;
   logic        btn_next;
   logic        freeze;
   logic [31:0] src0;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [31:0] src3;
   logic [1:0]  sel;
   logic [31:0] data;
   logic        busy;

   modport master (
      output btn_next, freeze, src0, src1, src2, src3,
      input  sel, data, busy
   );

   modport slave (
      input  btn_next, freeze, src0, src1, src2, src3,
      output sel, data, busy
   );
endinterface

// File: rtl/display_feed.sv
// Selects one of four status words with a debounced button and feeds the 7-seg driver.
// Define DISP_BCD_EN to convert the word to 8-digit packed BCD (saturating) before display.
module display_feed #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input logic          clk,
   input logic          rst,
   display_feed_if.slave bus
);
   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q, db_q;
   logic [CntW-1:0] cnt_q;
   logic [1:0]      sel_q;
   logic [31:0]     data_q;
   logic [31:0]     src_mux;
   logic            press;

   // Accepted rising level of the debounced button; sel steps on the same edge db rises.
   assign press = (sync2_q != db_q) && (cnt_q == CntMax) && sync2_q;

   always_comb begin
      src_mux = bus.src0;
      case (sel_q)
         2'd0: src_mux = bus.src0;
         2'd1: src_mux = bus.src1;
         2'd2: src_mux = bus.src2;
         2'd3: src_mux = bus.src3;
         default: src_mux = bus.src0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
         sel_q   <= 2'd0;
      end else begin
         sync1_q <= bus.btn_next;
         sync2_q <= sync1_q;
         if (sync2_q == db_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CntMax) begin
            db_q  <= sync2_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (press) sel_q <= sel_q + 2'd1;
      end
   end

   assign bus.sel  = sel_q;
   assign bus.data = data_q;

`ifdef DISP_BCD_EN
   typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

   state_e      state_q;
   logic [31:0] op_q;
   logic [39:0] acc_q;
   logic [39:0] acc_adj;
   logic [4:0]  bit_q;
   logic [1:0]  op_sel_q;
   logic        busy_q;

   // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < 10; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         op_q     <= '0;
         acc_q    <= '0;
         bit_q    <= '0;
         op_sel_q <= 2'd0;
         busy_q   <= 1'b0;
         data_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (!bus.freeze) begin
                  op_q     <= src_mux;
                  op_sel_q <= sel_q;
                  acc_q    <= '0;
                  bit_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= StShift;
               end
            end
            StShift: begin
               // A source switch mid-conversion abandons the stale operand.
               if (sel_q != op_sel_q) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  acc_q <= (acc_adj << 1) | {39'd0, op_q[31]};
                  op_q  <= op_q << 1;
                  bit_q <= bit_q + 5'd1;
                  if (bit_q == 5'd31) state_q <= StLoad;
               end
            end
            StLoad: begin
               // Freeze was low at capture, so high here means it rose mid-conversion.
               if (!bus.freeze) begin
                  data_q <= (acc_q[39:32] != 8'd0) ? 32'h9999_9999 : acc_q[31:0];
               end
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else if (!bus.freeze) begin
         data_q <= src_mux;
      end
   end

   assign bus.busy = 1'b0;
`endif
endmodule

// File: tb/tb_display_feed.sv
// Scoreboard bench for display_feed: stimulus queues edge-stamped expectations, a negedge
// monitor pops and compares them. Raw mode by default; BCD scenarios under DISP_BCD_EN.
module tb_display_feed;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   typedef struct {
      string       name;
      int          cyc;
      logic [1:0]  sel;
      logic [31:0] data;
      logic        busy;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   logic [31:0] srcv[4];

   display_feed_if bus();

   assign bus.src0 = srcv[0];
   assign bus.src1 = srcv[1];
   assign bus.src2 = srcv[2];
   assign bus.src3 = srcv[3];

   display_feed #(.DEBOUNCE_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         checks++;
         if (e.cyc != cyc || bus.sel !== e.sel || bus.data !== e.data || bus.busy !== e.busy) begin
            failures++;
            $display("FAIL %s edge=%0d: got sel=%0d data=%h busy=%b, want sel=%0d data=%h busy=%b",
                     e.name, e.cyc, bus.sel, bus.data, bus.busy, e.sel, e.data, e.busy);
         end
      end
   end

   task automatic expect_at(input string name, input int edge_n, input logic [1:0] s,
                            input logic [31:0] d, input logic b);
      exp_t x;
      x.name = name;
      x.cyc  = edge_n;
      x.sel  = s;
      x.data = d;
      x.busy = b;
      exp_q.push_back(x);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int edge_n);
      while (cyc < edge_n) step(1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: cycle budget expired at edge %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rst          = 1'b1;
      bus.btn_next = 1'b0;
      srcv[0]      = 32'hA5A5_0000;
      srcv[1]      = 32'h5A5A_1111;
      srcv[2]      = 32'h0F0F_2222;
      srcv[3]      = 32'hF0F0_3333;
      wait_until(1);
      checks++;
      if (bus.sel !== 2'd0) begin
         failures++;
         $display("FAIL reset_sel: got sel=%0d, want 0", bus.sel);
      end
      checks++;
      if (bus.data !== 32'h0) begin
         failures++;
         $display("FAIL reset_data: got data=%h, want 0", bus.data);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy: got busy=%b, want 0", bus.busy);
      end
`ifdef DISP_BCD_EN
      bus.freeze = 1'b1;
      expect_at("reset", 2, 2'd0, 32'h0, 1'b0);
      wait_until(2);
      begin
         int n1, n2, n3, n4, n5, n6;
         rst        = 1'b0;
         srcv[0]    = 32'd12345678;
         srcv[1]    = 32'd87654321;
         bus.freeze = 1'b0;
         n1 = cyc + 1;
         n2 = n1 + 34;
         n3 = n2 + 34;
         n4 = n3 + 34;
         n5 = n4 + 12;
         n6 = n5 + 34;
         expect_at("bcd_busy_rise", n1, 2'd0, 32'h0, 1'b1);
         expect_at("bcd_busy_last", n1 + 32, 2'd0, 32'h0, 1'b1);
         expect_at("bcd_12345678", n1 + 33, 2'd0, 32'h1234_5678, 1'b0);
         expect_at("bcd_recapture", n2, 2'd0, 32'h1234_5678, 1'b1);
         expect_at("bcd_saturate", n2 + 33, 2'd0, 32'h9999_9999, 1'b0);
         expect_at("bcd_zero", n3 + 33, 2'd0, 32'h0, 1'b0);
         expect_at("abort_sel_step", n4 + 10, 2'd1, 32'h0, 1'b1);
         expect_at("abort_idle", n4 + 11, 2'd1, 32'h0, 1'b0);
         expect_at("abort_recapture", n5, 2'd1, 32'h0, 1'b1);
         expect_at("abort_no_write", n4 + 33, 2'd1, 32'h0, 1'b1);
         expect_at("bcd_after_abort", n5 + 33, 2'd1, 32'h8765_4321, 1'b0);
         expect_at("rst_mid_before", n6 + 19, 2'd1, 32'h8765_4321, 1'b1);
         expect_at("rst_mid_shift", n6 + 20, 2'd0, 32'h0, 1'b0);
         expect_at("rst_then_frozen", n6 + 22, 2'd0, 32'h0, 1'b0);
         wait_until(n1);
         srcv[0] = 32'd100000000;
         wait_until(n2);
         srcv[0] = 32'd0;
         wait_until(n3);
         srcv[0] = 32'd555;
         wait_until(n4 + 4);
         bus.btn_next = 1'b1;
         wait_until(n4 + 12);
         bus.btn_next = 1'b0;
         wait_until(n6 + 19);
         rst = 1'b1;
         wait_until(n6 + 20);
         rst        = 1'b0;
         bus.freeze = 1'b1;
         wait_until(n6 + 25);
      end
`else
      bus.freeze = 1'b0;
      expect_at("reset", 2, 2'd0, 32'h0, 1'b0);
      wait_until(2);
      rst     = 1'b0;
      srcv[0] = 32'h1234_5678;
      srcv[1] = 32'hDEAD_BEEF;
      srcv[2] = 32'hCAFE_0002;
      srcv[3] = 32'h0BAD_0003;
      expect_at("raw_src0", cyc + 1, 2'd0, 32'h1234_5678, 1'b0);
      step(2);
      // Button held 10 cycles: sel steps exactly 6 edges after the rise.
      bus.btn_next = 1'b1;
      expect_at("btn_latency_pre", cyc + 5, 2'd0, 32'h1234_5678, 1'b0);
      expect_at("btn_latency_sel", cyc + 6, 2'd1, 32'h1234_5678, 1'b0);
      expect_at("btn_latency_data", cyc + 7, 2'd1, 32'hDEAD_BEEF, 1'b0);
      step(10);
      bus.btn_next = 1'b0;
      step(10);
      bus.btn_next = 1'b1;
      step(3);
      bus.btn_next = 1'b0;
      expect_at("short_pulse", cyc + 8, 2'd1, 32'hDEAD_BEEF, 1'b0);
      step(8);
      for (int k = 0; k < 4; k++) begin
         logic [1:0] ns;
         ns = 2'((k + 2) % 4);
         bus.btn_next = 1'b1;
         expect_at("press_sel", cyc + 6, ns, srcv[(k + 1) % 4], 1'b0);
         expect_at("press_data", cyc + 7, ns, srcv[ns], 1'b0);
         step(8);
         bus.btn_next = 1'b0;
         step(8);
      end
      bus.freeze = 1'b1;
      step(1);
      srcv[1] = 32'h0000_00FF;
      expect_at("freeze_hold", cyc + 3, 2'd1, 32'hDEAD_BEEF, 1'b0);
      step(3);
      bus.freeze = 1'b0;
      expect_at("freeze_release", cyc + 1, 2'd1, 32'h0000_00FF, 1'b0);
      step(2);
      bus.freeze   = 1'b1;
      bus.btn_next = 1'b1;
      expect_at("frozen_press_sel", cyc + 6, 2'd2, 32'h0000_00FF, 1'b0);
      expect_at("frozen_press_hold", cyc + 7, 2'd2, 32'h0000_00FF, 1'b0);
      step(8);
      bus.btn_next = 1'b0;
      step(8);
      bus.freeze = 1'b0;
      expect_at("frozen_release", cyc + 1, 2'd2, 32'hCAFE_0002, 1'b0);
      step(3);
`endif
      step(2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         failures++;
         $display("FAIL %s edge=%0d: got no sample, want sel=%0d data=%h busy=%b",
                  e.name, e.cyc, e.sel, e.data, e.busy);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
